// File: rtl/constraint_sampler_pkg.sv
// constraint_sampler_pkg: shared types and constants for the constraint sampler.
// Contents: FSM state enum, packed candidate layout (per-variable offset/width),
// LFSR tap mask, reset/zero-seed substitute value and the LFSR step function.
package constraint_sampler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGen,
    StEval,
    StEmit,
    StFin
  } state_e;

  localparam int unsigned VAR_BITS = 62;

  localparam int unsigned VAR0_OFF = 0;
  localparam int unsigned VAR0_W   = 13;
  localparam int unsigned VAR1_OFF = 13;
  localparam int unsigned VAR1_W   = 13;
  localparam int unsigned VAR2_OFF = 26;
  localparam int unsigned VAR2_W   = 14;
  localparam int unsigned VAR3_OFF = 40;
  localparam int unsigned VAR3_W   = 14;
  localparam int unsigned VAR4_OFF = 54;
  localparam int unsigned VAR4_W   = 8;

  // Taps 64,63,61,60 (1-based) -> bits 63,62,60,59.
  localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DEFAULT_SEED = 64'h1;

  // Fibonacci step: shift left, XOR of tapped bits enters at bit 0.
  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/constraint_sampler_ctrl_if.sv
// constraint_sampler_ctrl_if: sample output handshake of the constraint sampler.
// Signals: sample_valid (sampler -> consumer), sample_ready (consumer -> sampler),
// sample_data [VAR_BITS-1:0] (sampler -> consumer).
// Modports: master = sampler side, slave = consumer side.
interface constraint_sampler_ctrl_if;
  import constraint_sampler_pkg::*;

  logic                sample_valid;
  logic                sample_ready;
  logic [VAR_BITS-1:0] sample_data;

  modport master (output sample_valid, output sample_data, input sample_ready);
  modport slave  (input sample_valid, input sample_data, output sample_ready);

endinterface

// File: rtl/sampler_lfsr64.sv
// sampler_lfsr64: 64-bit Fibonacci LFSR with seed load and advance enable.
// Ports: clk, rst_n (sync, active low), load + seed (zero seed replaced by
// DEFAULT_SEED), adv (one step per cycle when high), value = low VAR_BITS bits
// of the current state.
module sampler_lfsr64
  import constraint_sampler_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [63:0]         seed,
  input  logic                adv,
  output logic [VAR_BITS-1:0] value
);

  logic [63:0] state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DEFAULT_SEED;
    end else if (load) begin
      // An all-zero state would lock the LFSR.
      state_q <= (seed == 64'd0) ? DEFAULT_SEED : seed;
    end else if (adv) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign value = state_q[VAR_BITS-1:0];

endmodule

// File: rtl/constraint_sampler_ctrl.sv
// constraint_sampler_ctrl: drives LFSR candidates into a combinational constraint
// block, accepts those whose masked outputs are all true and emits them over a
// valid/ready handshake until num_samples are produced or a sample runs out of
// retries (timeout).
// Ports: clk, rst_n (sync, active low); seed_load/seed, start/num_samples/cons_mask
// (honoured in IDLE only); cand_vars -> block, cons_in <- block; smp (master
// modport: sample_valid/sample_ready/sample_data); busy, done (pulse), timeout
// (sticky until next start).
// Build option SAMPLER_STATS_EN adds stat_rejects (saturating reject count) and
// stat_fail_hist (sticky OR of failing masked constraints), cleared per run.
module constraint_sampler_ctrl
  import constraint_sampler_pkg::*;
#(
  parameter int unsigned NUM_CONS  = 8,
  parameter int unsigned MAX_TRIES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      seed_load,
  input  logic [63:0]               seed,
  input  logic                      start,
  input  logic [15:0]               num_samples,
  input  logic [NUM_CONS-1:0]       cons_mask,
  output logic [VAR_BITS-1:0]       cand_vars,
  input  logic [NUM_CONS-1:0]       cons_in,
  constraint_sampler_ctrl_if.master smp,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout
`ifdef SAMPLER_STATS_EN
  ,
  output logic [31:0]               stat_rejects,
  output logic [NUM_CONS-1:0]       stat_fail_hist
`endif
);

  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  state_e              state_q;
  logic [VAR_BITS-1:0] cand_q, data_q, lfsr_val;
  logic                valid_q, busy_q, done_q, timeout_q;
  logic [NUM_CONS-1:0] mask_q;
  logic [15:0]         num_q, samp_q, samp_inc;
  logic [TRY_W-1:0]    try_q;
  logic                pass;

  sampler_lfsr64 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  ((state_q == StIdle) && seed_load),
    .seed  (seed),
    .adv   (state_q == StGen),
    .value (lfsr_val)
  );

  // Unmasked constraints count as satisfied.
  assign pass     = &(cons_in | ~mask_q);
  assign samp_inc = samp_q + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cand_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      mask_q    <= '0;
      num_q     <= '0;
      samp_q    <= '0;
      try_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
            if (num_samples == 16'd0) begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end else begin
              num_q   <= num_samples;
              mask_q  <= cons_mask;
              samp_q  <= '0;
              try_q   <= '0;
              state_q <= StGen;
            end
          end
        end
        StGen: begin
          // Fields packed explicitly so the layout lives in one place.
          cand_q  <= {lfsr_val[VAR4_OFF +: VAR4_W], lfsr_val[VAR3_OFF +: VAR3_W],
                      lfsr_val[VAR2_OFF +: VAR2_W], lfsr_val[VAR1_OFF +: VAR1_W],
                      lfsr_val[VAR0_OFF +: VAR0_W]};
          state_q <= StEval;
        end
        StEval: begin
          if (pass) begin
            data_q  <= cand_q;
            valid_q <= 1'b1;
            state_q <= StEmit;
          end else if (try_q == TRY_LAST) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= StFin;
          end else begin
            try_q   <= try_q + 1'b1;
            state_q <= StGen;
          end
        end
        StEmit: begin
          if (smp.sample_ready) begin
            valid_q <= 1'b0;
            samp_q  <= samp_inc;
            try_q   <= '0;
            if (samp_inc == num_q) begin
              done_q  <= 1'b1;
              state_q <= StFin;
            end else begin
              state_q <= StGen;
            end
          end
        end
        StFin: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cand_vars        = cand_q;
  assign smp.sample_valid = valid_q;
  assign smp.sample_data  = data_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign timeout          = timeout_q;

`ifdef SAMPLER_STATS_EN
  logic [31:0]         rej_q;
  logic [NUM_CONS-1:0] hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rej_q  <= '0;
      hist_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      rej_q  <= '0;
      hist_q <= '0;
    end else if ((state_q == StEval) && !pass) begin
      if (~&rej_q) rej_q <= rej_q + 32'd1;
      hist_q <= hist_q | (~cons_in & mask_q);
    end
  end

  assign stat_rejects   = rej_q;
  assign stat_fail_hist = hist_q;
`endif

endmodule
